dmem_lat: RTL and testbench

Parametrised, multi-cycle data memory for the pipelined MIPS core, replacing the single-cycle word/half/byte store memory and the separate load-extension logic. It accepts one request at a time through a req/busy/done handshake and completes it after a programmable latency. Stores write byte lanes; loads return sign- or zero-extended bytes, halves or words. Misaligned and reserved-size accesses are rejected with an error flag. The pipeline's memory stage stalls on `busy`.

---
 rtl/dmem_lat_if.sv | 32 +++
 rtl/dmem_lat.sv | 193 +++++++++++++++++++
 tb/tb_dmem_lat.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lat_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lat_if
//  Description : Request/response bundle between the memory stage and the
//                multi-cycle data memory (req/busy/done handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_lat_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] a;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] rd;
    logic        err;

    // Pipeline memory stage side
    modport master (
        output req, we, size, ld_unsigned, a, wd,
        input  busy, done, rd, err
    );

    // Memory side
    modport slave (
        input  req, we, size, ld_unsigned, a, wd,
        output busy, done, rd, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lat.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lat
//  Description : Multi-cycle byte/half/word data memory with programmable
//                latency, load sign/zero extension and misalignment errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lat #(
    parameter int DEPTH   = 64,   // words, power of two, >= 2
    parameter int LATENCY = 2     // accept edge to completion edge, >= 1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    dmem_lat_if.slave   bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_ERRWAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;

    // Request captured at the accept edge
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [c_AW+1:0]   r_a;
    logic [31:0]       r_wd;

    // Registered outputs
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rd;

    logic              w_accept;
    logic              w_complete;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_misalign;

    logic [31:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   w_idx;
    logic [31:0]       w_word;
    logic [31:0]       w_wmask;
    logic [31:0]       w_wdata;
    logic [7:0]        w_lane8;
    logic [15:0]       w_lane16;
    logic [31:0]       w_ld_data;

    // Upper address bits fall outside the memory and wrap by design
    logic              w_unused_a;
    assign w_unused_a = &{1'b0, bus.a[31:c_AW+2]};

    assign w_misalign = (bus.size == 2'b11)
                      | ((bus.size == 2'b01) & bus.a[0])
                      | ((bus.size == 2'b10) & (bus.a[1:0] != 2'b00));

    assign w_idx    = r_a[c_AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_lane8  = w_word[{r_a[1:0], 3'b000} +: 8];
    assign w_lane16 = r_a[1] ? w_word[31:16] : w_word[15:0];

    // Next-state logic: accept in IDLE, count down in BUSY, one-cycle error hop
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept = 1'b1;
                    if (w_misalign) begin
                        w_state_nxt = S_ERRWAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_complete  = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERRWAIT: begin
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Lane mask and replicated data for the store being committed
    always_comb begin
        w_wmask = '0;
        w_wdata = '0;
        case (r_size)
            2'b00: begin
                w_wmask = 32'h0000_00FF << {r_a[1:0], 3'b000};
                w_wdata = {4{r_wd[7:0]}};
            end
            2'b01: begin
                w_wmask = r_a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wdata = {2{r_wd[15:0]}};
            end
            default: begin
                w_wmask = 32'hFFFF_FFFF;
                w_wdata = r_wd;
            end
        endcase
    end

    // Lane extraction with sign or zero extension for loads
    always_comb begin
        w_ld_data = w_word;
        case (r_size)
            2'b00:   w_ld_data = r_uns ? {24'h0, w_lane8}
                                       : {{24{w_lane8[7]}}, w_lane8};
            2'b01:   w_ld_data = r_uns ? {16'h0, w_lane16}
                                       : {{16{w_lane16[15]}}, w_lane16};
            default: w_ld_data = w_word;
        endcase
    end

    // State, request capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_a     <= '0;
            r_wd    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_we   <= bus.we;
                r_size <= bus.size;
                r_uns  <= bus.ld_unsigned;
                r_a    <= bus.a[c_AW+1:0];
                r_wd   <= bus.wd;
            end
            if (w_complete && !r_we) begin
                r_rd <= w_ld_data;
            end
        end
    end

    // Store commit at the completion edge; reset suppresses a pending store
    always_ff @(posedge clk) begin
        if (!reset && w_complete && r_we) begin
            r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.rd   = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_lat
//  Description : Scoreboard bench for dmem_lat: requests push expected
//                err/rd/latency, completions pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lat;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] m [DEPTH];
    logic [31:0] model_rd = '0;

    dmem_lat_if bus();

    dmem_lat #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("err", {31'b0, bus.err}, {31'b0, mon_e.err});
                chk("rd", bus.rd, mon_e.rd);
                chk("latency", 32'(cyc - mon_e.acc), mon_e.err ? 32'd1 : 32'(LATENCY));
                chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
            end
        end
    end

    // Issue one request once the memory is idle and record what it must return
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input bit hold);
        exp_t        e;
        int          idx;
        int          n;
        bit          bad;
        logic [31:0] wv;
        logic [7:0]  b;
        logic [15:0] h;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 50);
        if (bus.busy) begin
            chk("issue_timeout", 32'd1, 32'd0);
            return;
        end
        bus.req         = 1'b1;
        bus.we          = w;
        bus.size        = sz;
        bus.ld_unsigned = uns;
        bus.a           = addr;
        bus.wd          = data;
        bad = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        idx = int'((addr >> 2) % DEPTH);
        if (!bad) begin
            wv = m[idx];
            if (w) begin
                case (sz)
                    2'b00:   wv[8*int'(addr[1:0]) +: 8] = data[7:0];
                    2'b01:   wv[16*int'(addr[1]) +: 16] = data[15:0];
                    default: wv = data;
                endcase
                m[idx] = wv;
            end else begin
                b = wv[8*int'(addr[1:0]) +: 8];
                h = wv[16*int'(addr[1]) +: 16];
                case (sz)
                    2'b00:   model_rd = uns ? {24'h0, b} : {{24{b[7]}}, b};
                    2'b01:   model_rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
                    default: model_rd = wv;
                endcase
            end
        end
        e.err = bad;
        e.rd  = model_rd;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.req = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.ld_unsigned = 1'b0;
        bus.a = '0; bus.wd = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_err",  {31'b0, bus.err},  32'd0);
        chk("rst_rd",   bus.rd, 32'd0);

        // Word store / load
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

        // Byte store into a word, signed and unsigned byte loads
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);

        // Half lanes
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE1234, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // Rejected requests, then confirm memory untouched
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h00007777, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // req pulsed while busy must be dropped
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.a = 32'h10; bus.wd = 32'h00000BAD;
        @(posedge clk);
        #1 bus.req = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

        // req held high across back-to-back accesses
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);

        // Address wrap
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hA5A50001, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0);
        drain();

        // Reset during a store aborts it
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.a = 32'h30; bus.wd = 32'h00000055;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_rd",   bus.rd, 32'd0);
        model_rd = '0;
        reset = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
